hangman_game_ctrl: RTL
======================

# hangman_game_ctrl

Game sequencer for the Hangman display path. It accepts a secret word of up to 10 characters, then accepts guesses through a valid/ready handshake and scans the word one position per cycle. From that scan it maintains the reveal mask and the miss count, and drives `letter_one`…`letter_ten` and `incorrect` straight into `VGA_interpreter`. It owns all game state; the display side only renders what this block presents.

## Interface
- `WORD_MAX`, 10: character slots; fixed to match the ten display inputs.
- `MAX_MISSES`, 6: misses that end the game; must be ≤ 15.
- `clk`  in  1  master clock, 50 MHz.
- `clr`  in  1  reset. One clock; reset is synchronous and active-high.
- `load_valid`  in  1  word character present.
- `load_char`  in  8  ASCII character.
- `load_last`  in  1  marks the final character of the word.
- `load_ready`  out  1  high only in IDLE.
- `guess_valid`  in  1  guess present.
- `guess_char`  in  8  ASCII guess.
- `guess_ready`  out  1  high only in PLAY.
- `new_game`  in  1  return from WON/LOST to IDLE.
- `letter_one`…`letter_ten`  out  8 each  display characters.
- `incorrect`  out  4  miss count.
- `win`, `lose`  out  1  high while in WON / LOST.

## Operation
- **States.** IDLE, PLAY, SCAN, RESOLVE, WON, LOST.
- **IDLE, loading the word.**
  - Each cycle with `load_valid` high stores `load_char` at slot `len` and increments `len`.
  - Characters arriving once `len` = `WORD_MAX` are dropped.
  - Characters outside 'A'–'Z' and 'a'–'z' are stored pre-revealed (space, hyphen).
  - Letters are stored folded to upper case and unrevealed.
  - `load_last` accepted → PLAY. `len` is ≥ 1 by construction.
- **PLAY, accepting a guess.**
  - A guess is accepted on a cycle with `guess_valid` and `guess_ready` both high.
  - The guess is folded to upper case.
  - A non-letter guess, or a letter already set in the 26-bit guessed mask, is consumed with no effect and the block stays in PLAY.
  - Otherwise: set the guessed bit, clear the hit flag, set idx = 0, go to SCAN.
- **SCAN.** Each cycle compares slot idx (idx < `len`) with the guess. On a match, reveal that slot and set the hit flag. idx increments; after idx = `WORD_MAX`−1 → RESOLVE.
- **RESOLVE.**
  - If there was no hit, `incorrect` increments, saturating at `MAX_MISSES`.
  - Then: all slots < `len` revealed → WON; else `incorrect` = `MAX_MISSES` → LOST; else → PLAY.
  - Win takes priority if both conditions hold (not reachable, because a hit never adds a miss).
- **WON / LOST.** Outputs are frozen. `new_game` → IDLE, clearing the word, `len`, reveal mask, guessed mask and `incorrect`. `new_game` is ignored in every other state.
- **Display mapping.** For slot k: k ≥ `len` → 8'h20; revealed → the stored char; else 8'h5F ('_'). `letter_one` is slot 0.
- **Reset.** `clr` in any state, including mid-SCAN: state = IDLE, `len` = 0, all masks cleared, `incorrect` = 0, `win` = `lose` = 0. All letter outputs read 8'h20, `load_ready` = 1, `guess_ready` = 0.

## Timing
- A load character accepted at edge N is visible on the letter outputs after edge N, as '_' or as the char.
- Guess accepted at edge N:
  - SCAN runs at edges N+1 … N+`WORD_MAX`. Each reveal becomes visible the cycle after its slot's edge.
  - RESOLVE is at edge N+`WORD_MAX`+1. `incorrect`, `win` and `lose` update there.
  - `guess_ready` returns high at N+`WORD_MAX`+1 if the game continues.
- Guess rate is therefore 1 per `WORD_MAX`+2 cycles. An ignored guess costs 1 cycle.
- All outputs are registered, or decoded combinationally from registers only; there are no input-to-output combinational paths.
- Simultaneous `clr` and any other input: `clr` wins.

## Structure
- **Package `hangman_pkg`.** State enum, `CHAR_BLANK` = 8'h20, `CHAR_HIDDEN` = 8'h5F, `WORD_MAX`, and the letter-index type (5 bits).
- **Sub-module `hangman_letter_norm`.** Combinational. Input 8-bit ASCII; outputs `is_letter`, upper-case char and 5-bit index 0–25. It is instantiated twice: once for the load path and once for the guess path.
- **Top level.** The FSM, word registers, masks and output decode live in the top level.

## Test plan
- **Load and initial display.** Load "CAT" (last on 'T') → `letter_one`..`three` = 5F, the remaining seven = 20, `incorrect` = 0, `guess_ready` = 1.
- **Hit and reveal.** Guess 'a' → after 12 cycles `letter_two` = 41, `incorrect` = 0. Guess 'Q' → `incorrect` = 1.
- **Repeated and invalid guesses.** Repeat 'A', then '7' → each consumed in 1 cycle, `incorrect` unchanged, no reveal.
- **Win.** "CAT", guesses C, A, T → `win` = 1 at RESOLVE of 'T'. `guess_ready` = 0. A further `guess_valid` is not accepted.
- **Loss and restart.** "HI", six wrong guesses → `incorrect` = 6, `lose` = 1. `new_game` → IDLE, all letters 20, `incorrect` = 0.
- **Overflow load and reset mid-scan.**
  - A 12-character load keeps the first 10.
  - "A-B" shows `letter_two` = 2D immediately.
  - `clr` asserted during SCAN → next cycle IDLE, all letters 20.

Source files
------------

// File: rtl/hangman_pkg.sv
// hangman_pkg: shared definitions for the Hangman game sequencer.
//   WORD_MAX     - number of character slots (ties to the ten display inputs)
//   ALPHABET     - width of the guessed-letter mask
//   CHAR_BLANK   - shown for slots beyond the loaded word
//   CHAR_HIDDEN  - shown for letters not yet guessed
//   letter_idx_t - 0..25 index of an upper-case letter
//   state_t      - sequencer states
package hangman_pkg;

  localparam int WORD_MAX = 10;
  localparam int ALPHABET = 26;

  localparam logic [7:0] CHAR_BLANK  = 8'h20;
  localparam logic [7:0] CHAR_HIDDEN = 8'h5F;

  typedef logic [4:0] letter_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_SCAN,
    ST_RESOLVE,
    ST_WON,
    ST_LOST
  } state_t;

endpackage

// File: rtl/hangman_letter_norm.sv
// hangman_letter_norm: combinational ASCII classifier / case folder.
//   ch        in  8  raw ASCII character
//   is_letter out 1  ch is in 'A'-'Z' or 'a'-'z'
//   upper     out 8  ch folded to upper case (non-letters pass through)
//   idx       out 5  0..25 letter index of upper (0 for non-letters)
module hangman_letter_norm
  import hangman_pkg::*;
(
  input  logic [7:0]  ch,
  output logic        is_letter,
  output logic [7:0]  upper,
  output letter_idx_t idx
);

  logic is_up;
  logic is_lo;

  assign is_up     = (ch >= 8'h41) && (ch <= 8'h5A);
  assign is_lo     = (ch >= 8'h61) && (ch <= 8'h7A);
  assign is_letter = is_up | is_lo;
  assign upper     = is_lo ? (ch - 8'h20) : ch;

  // 'A'..'Z' are 0x41..0x5A, so the low five bits run 1..26.
  assign idx = is_letter ? (upper[4:0] - 5'd1) : '0;

endmodule

// File: rtl/hangman_game_ctrl.sv
// hangman_game_ctrl: Hangman game sequencer feeding the VGA interpreter.
//   clk, clr                 clock and synchronous active-high reset
//   load_valid/char/last     word loading (accepted in IDLE only)
//   load_ready               high in IDLE
//   guess_valid/char         guess handshake (accepted in PLAY only)
//   guess_ready              high in PLAY
//   new_game                 leave WON/LOST for IDLE
//   letter_one..letter_ten   display characters, slot 0..9
//   incorrect                miss count
//   win, lose                high while in WON / LOST
module hangman_game_ctrl
  import hangman_pkg::*;
#(
  parameter int MAX_MISSES = 6
)
(
  input  logic       clk,
  input  logic       clr,
  input  logic       load_valid,
  input  logic [7:0] load_char,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       guess_valid,
  input  logic [7:0] guess_char,
  output logic       guess_ready,
  input  logic       new_game,
  output logic [7:0] letter_one,
  output logic [7:0] letter_two,
  output logic [7:0] letter_three,
  output logic [7:0] letter_four,
  output logic [7:0] letter_five,
  output logic [7:0] letter_six,
  output logic [7:0] letter_seven,
  output logic [7:0] letter_eight,
  output logic [7:0] letter_nine,
  output logic [7:0] letter_ten,
  output logic [3:0] incorrect,
  output logic       win,
  output logic       lose
);

  localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);
  localparam logic [3:0] SLOTS      = 4'(WORD_MAX);
  localparam logic [3:0] LAST_SLOT  = 4'(WORD_MAX - 1);

  state_t                state_reg;
  logic [7:0]            word_reg [WORD_MAX];
  logic [WORD_MAX-1:0]   reveal_reg;
  logic [ALPHABET-1:0]   guessed_reg;
  logic [3:0]            len_reg;
  logic [3:0]            idx_reg;
  logic [3:0]            incorrect_reg;
  logic                  hit_reg;
  logic [7:0]            guess_up_reg;

  // Load path: only the fold and the letter/non-letter class are needed.
  logic        load_is_letter;
  logic [7:0]  load_upper;
  letter_idx_t load_idx_unused;

  logic        guess_is_letter;
  logic [7:0]  guess_upper;
  letter_idx_t guess_idx;

  hangman_letter_norm u_load_norm (
    .ch        (load_char),
    .is_letter (load_is_letter),
    .upper     (load_upper),
    .idx       (load_idx_unused)
  );

  hangman_letter_norm u_guess_norm (
    .ch        (guess_char),
    .is_letter (guess_is_letter),
    .upper     (guess_upper),
    .idx       (guess_idx)
  );

  logic [WORD_MAX-1:0] in_word;
  logic [7:0]          disp [WORD_MAX];
  logic                all_revealed;
  logic [3:0]          miss_next;

  for (genvar gi = 0; gi < WORD_MAX; gi++) begin : g_slot
    assign in_word[gi] = 4'(gi) < len_reg;
    assign disp[gi]    = !in_word[gi]    ? CHAR_BLANK  :
                         reveal_reg[gi]  ? word_reg[gi] : CHAR_HIDDEN;
  end

  // Slots beyond the word count as revealed so an unused tail never blocks a win.
  assign all_revealed = &(reveal_reg | ~in_word);

  assign miss_next = hit_reg ? incorrect_reg :
                     (incorrect_reg < MISS_LIMIT) ? incorrect_reg + 4'd1 : incorrect_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      idx_reg       <= '0;
      reveal_reg    <= '0;
      guessed_reg   <= '0;
      incorrect_reg <= '0;
      hit_reg       <= 1'b0;
      guess_up_reg  <= '0;
      for (int i = 0; i < WORD_MAX; i++) word_reg[i] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (load_valid) begin
            if (len_reg < SLOTS) begin
              word_reg[len_reg]   <= load_upper;
              reveal_reg[len_reg] <= !load_is_letter;
              len_reg             <= len_reg + 4'd1;
            end
            if (load_last) state_reg <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          // Non-letters and repeats are consumed here without leaving PLAY.
          if (guess_valid && guess_is_letter && !guessed_reg[guess_idx]) begin
            guessed_reg[guess_idx] <= 1'b1;
            guess_up_reg           <= guess_upper;
            hit_reg                <= 1'b0;
            idx_reg                <= '0;
            state_reg              <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if ((idx_reg < len_reg) && (word_reg[idx_reg] == guess_up_reg)) begin
            reveal_reg[idx_reg] <= 1'b1;
            hit_reg             <= 1'b1;
          end
          // Always walk every slot so a guess has a fixed cost.
          if (idx_reg == LAST_SLOT) state_reg <= ST_RESOLVE;
          else                      idx_reg   <= idx_reg + 4'd1;
        end
        ST_RESOLVE: begin
          incorrect_reg <= miss_next;
          if (all_revealed)                 state_reg <= ST_WON;
          else if (miss_next == MISS_LIMIT) state_reg <= ST_LOST;
          else                              state_reg <= ST_PLAY;
        end
        ST_WON, ST_LOST: begin
          if (new_game) begin
            state_reg     <= ST_IDLE;
            len_reg       <= '0;
            reveal_reg    <= '0;
            guessed_reg   <= '0;
            incorrect_reg <= '0;
            for (int i = 0; i < WORD_MAX; i++) word_reg[i] <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign load_ready  = (state_reg == ST_IDLE);
  assign guess_ready = (state_reg == ST_PLAY);
  assign win         = (state_reg == ST_WON);
  assign lose        = (state_reg == ST_LOST);
  assign incorrect   = incorrect_reg;

  assign letter_one   = disp[0];
  assign letter_two   = disp[1];
  assign letter_three = disp[2];
  assign letter_four  = disp[3];
  assign letter_five  = disp[4];
  assign letter_six   = disp[5];
  assign letter_seven = disp[6];
  assign letter_eight = disp[7];
  assign letter_nine  = disp[8];
  assign letter_ten   = disp[9];

endmodule
